// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares one GMII TX path between ARP, ICMP and UDP
// generators with ARP priority, ICMP/UDP round-robin, IFG and watchdog.
module eth_tx_arbiter #(
   parameter int IFG_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arp_tx_req,
   output logic       arp_tx_en,
   input  logic       arp_tx_done,
   input  logic       arp_gmii_tx_en,
   input  logic [7:0] arp_gmii_txd,
   input  logic       icmp_tx_req,
   output logic       icmp_tx_en,
   input  logic       icmp_tx_done,
   input  logic       icmp_gmii_tx_en,
   input  logic [7:0] icmp_gmii_txd,
   input  logic       udp_tx_req,
   output logic       udp_tx_en,
   input  logic       udp_tx_done,
   input  logic       udp_gmii_tx_en,
   input  logic [7:0] udp_gmii_txd,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       tx_busy,
   output logic [1:0] grant_id,
   output logic       tx_timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_IFG   = 2'd3
   } state_t;

   localparam logic [1:0]  G_NONE   = 2'd0;
   localparam logic [1:0]  G_ARP    = 2'd1;
   localparam logic [1:0]  G_ICMP   = 2'd2;
   localparam logic [1:0]  G_UDP    = 2'd3;
   localparam logic [15:0] WD_LOAD  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_grant;
   logic [1:0]  w_winner;
   logic        r_pend_arp;
   logic        r_pend_icmp;
   logic        r_pend_udp;
   logic        r_rr_udp;
   logic [15:0] r_wd;
   logic [7:0]  r_ifg;
   logic        r_gmii_en;
   logic [7:0]  r_gmii_txd;

   logic        w_contend;
   logic        w_sel_en;
   logic [7:0]  w_sel_txd;
   logic        w_sel_done;
   logic        w_fwd;
   logic        w_timeout;
   logic        w_clr_arp;
   logic        w_clr_icmp;
   logic        w_clr_udp;
   logic        w_grant_load;
   logic        w_grant_free;

   // Pointer only advances when ICMP and UDP actually compete.
   assign w_contend = r_pend_icmp & r_pend_udp & ~r_pend_arp;

   always_comb begin
      w_winner = G_NONE;
      if (r_pend_arp)
         w_winner = G_ARP;
      else if (w_contend)
         w_winner = r_rr_udp ? G_UDP : G_ICMP;
      else if (r_pend_icmp)
         w_winner = G_ICMP;
      else if (r_pend_udp)
         w_winner = G_UDP;
   end

   always_comb begin
      w_sel_en   = 1'b0;
      w_sel_txd  = 8'd0;
      w_sel_done = 1'b0;
      case (r_grant)
         G_ARP: begin
            w_sel_en   = arp_gmii_tx_en;
            w_sel_txd  = arp_gmii_txd;
            w_sel_done = arp_tx_done;
         end
         G_ICMP: begin
            w_sel_en   = icmp_gmii_tx_en;
            w_sel_txd  = icmp_gmii_txd;
            w_sel_done = icmp_tx_done;
         end
         G_UDP: begin
            w_sel_en   = udp_gmii_tx_en;
            w_sel_txd  = udp_gmii_txd;
            w_sel_done = udp_tx_done;
         end
         default: begin
            w_sel_en   = 1'b0;
            w_sel_txd  = 8'd0;
            w_sel_done = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fwd       = 1'b0;
      w_timeout   = 1'b0;
      arp_tx_en   = 1'b0;
      icmp_tx_en  = 1'b0;
      udp_tx_en   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_winner != G_NONE)
               w_state_nxt = S_START;
         end
         S_START: begin
            w_state_nxt = S_BUSY;
            w_fwd       = 1'b1;
            arp_tx_en   = (r_grant == G_ARP);
            icmp_tx_en  = (r_grant == G_ICMP);
            udp_tx_en   = (r_grant == G_UDP);
         end
         S_BUSY: begin
            w_fwd = 1'b1;
            if (w_sel_done) begin
               w_state_nxt = S_IFG;
            end else if (r_wd == 16'd0) begin
               // Aborted frame: drop the expiring cycle's byte too.
               w_state_nxt = S_IFG;
               w_fwd       = 1'b0;
               w_timeout   = 1'b1;
            end
         end
         S_IFG: begin
            if (r_ifg <= 8'd1)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_clr_arp    = (r_state == S_START) && (r_grant == G_ARP);
   assign w_clr_icmp   = (r_state == S_START) && (r_grant == G_ICMP);
   assign w_clr_udp    = (r_state == S_START) && (r_grant == G_UDP);
   assign w_grant_load = (r_state == S_IDLE) && (w_state_nxt == S_START);
   assign w_grant_free = (r_state == S_IFG) && (w_state_nxt == S_IDLE);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant     <= G_NONE;
         r_pend_arp  <= 1'b0;
         r_pend_icmp <= 1'b0;
         r_pend_udp  <= 1'b0;
         r_rr_udp    <= 1'b0;
         r_wd        <= 16'd0;
         r_ifg       <= 8'd0;
         r_gmii_en   <= 1'b0;
         r_gmii_txd  <= 8'd0;
      end else begin
         // A request in the clearing cycle re-arms the flag.
         r_pend_arp  <= (r_pend_arp & ~w_clr_arp) | arp_tx_req;
         r_pend_icmp <= (r_pend_icmp & ~w_clr_icmp) | icmp_tx_req;
         r_pend_udp  <= (r_pend_udp & ~w_clr_udp) | udp_tx_req;

         if (w_grant_load) begin
            r_grant <= w_winner;
            if (w_contend)
               r_rr_udp <= ~r_rr_udp;
         end else if (w_grant_free) begin
            r_grant <= G_NONE;
         end

         if (r_state == S_START)
            r_wd <= WD_LOAD;
         else if (r_state == S_BUSY && r_wd != 16'd0)
            r_wd <= r_wd - 16'd1;

         if (r_state == S_BUSY && w_state_nxt == S_IFG)
            r_ifg <= IFG_LOAD;
         else if (r_state == S_IFG && r_ifg != 8'd0)
            r_ifg <= r_ifg - 8'd1;

         r_gmii_en  <= w_fwd & w_sel_en;
         r_gmii_txd <= w_fwd ? w_sel_txd : 8'd0;
      end
   end

   assign gmii_tx_en = r_gmii_en;
   assign gmii_txd   = r_gmii_txd;
   assign tx_busy    = (r_state != S_IDLE);
   assign grant_id   = r_grant;
   assign tx_timeout = w_timeout;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench for eth_tx_arbiter with directed
// vectors; expected start pulses, bytes and timeouts are queued up front.
module tb_eth_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       arp_tx_req, icmp_tx_req, udp_tx_req;
   logic       arp_tx_en, icmp_tx_en, udp_tx_en;
   logic       arp_tx_done, icmp_tx_done, udp_tx_done;
   logic       arp_gmii_tx_en, icmp_gmii_tx_en, udp_gmii_tx_en;
   logic [7:0] arp_gmii_txd, icmp_gmii_txd, udp_gmii_txd;
   logic       gmii_tx_en;
   logic [7:0] gmii_txd;
   logic       tx_busy;
   logic [1:0] grant_id;
   logic       tx_timeout;

   logic [2:0] done_v = 3'b000;
   logic [2:0] spur   = 3'b000;

   assign arp_tx_done  = done_v[0] | spur[0];
   assign icmp_tx_done = done_v[1] | spur[1];
   assign udp_tx_done  = done_v[2] | spur[2];

   eth_tx_arbiter #(
      .IFG_CYCLES     (12),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .arp_tx_req      (arp_tx_req),
      .arp_tx_en       (arp_tx_en),
      .arp_tx_done     (arp_tx_done),
      .arp_gmii_tx_en  (arp_gmii_tx_en),
      .arp_gmii_txd    (arp_gmii_txd),
      .icmp_tx_req     (icmp_tx_req),
      .icmp_tx_en      (icmp_tx_en),
      .icmp_tx_done    (icmp_tx_done),
      .icmp_gmii_tx_en (icmp_gmii_tx_en),
      .icmp_gmii_txd   (icmp_gmii_txd),
      .udp_tx_req      (udp_tx_req),
      .udp_tx_en       (udp_tx_en),
      .udp_tx_done     (udp_tx_done),
      .udp_gmii_tx_en  (udp_gmii_tx_en),
      .udp_gmii_txd    (udp_gmii_txd),
      .gmii_tx_en      (gmii_tx_en),
      .gmii_txd        (gmii_txd),
      .tx_busy         (tx_busy),
      .grant_id        (grant_id),
      .tx_timeout      (tx_timeout)
   );

   always #4 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int id;
   } ev_t;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } by_t;

   ev_t q_start[$];
   by_t q_byte[$];
   int  q_tmo[$];

   int   checks = 0;
   int   errors = 0;
   logic idle_chk = 1'b0;
   logic final_chk = 1'b0;

   int start_cyc[3] = '{0, 0, 0};
   int start_cnt[3] = '{0, 0, 0};
   int served[3]    = '{0, 0, 0};
   int dly[3]       = '{20, 20, 20};

   // Monitor: pops and compares whenever the DUT shows an event.
   initial begin
      ev_t        e;
      by_t        b;
      int         t;
      int         id;
      logic [2:0] ev;
      logic [2:0] exp_v;
      logic [14:0] outs;
      forever begin
         @(negedge clk);
         ev = {udp_tx_en, icmp_tx_en, arp_tx_en};
         if (ev != 3'b000) begin
            id = ev[0] ? 1 : (ev[1] ? 2 : 3);
            checks++;
            if (q_start.size() == 0) begin
               errors++;
               $display("FAIL start_unexpected: cycle %0d en=%b, required none",
                        cyc, ev);
            end else begin
               e = q_start.pop_front();
               exp_v = 3'b001 << (e.id - 1);
               if (e.cyc != cyc || ev != exp_v || grant_id != 2'(e.id)) begin
                  errors++;
                  $display("FAIL start: cycle %0d en=%b grant=%0d, required cycle %0d en=%b grant=%0d",
                           cyc, ev, grant_id, e.cyc, exp_v, e.id);
               end
            end
            start_cyc[id-1] = cyc;
            start_cnt[id-1]++;
         end
         if (gmii_tx_en === 1'b1) begin
            checks++;
            if (q_byte.size() == 0) begin
               errors++;
               $display("FAIL byte_unexpected: cycle %0d txd=%h, required none",
                        cyc, gmii_txd);
            end else begin
               b = q_byte.pop_front();
               if (b.cyc != cyc || b.d !== gmii_txd) begin
                  errors++;
                  $display("FAIL byte: cycle %0d txd=%h, required cycle %0d txd=%h",
                           cyc, gmii_txd, b.cyc, b.d);
               end
            end
         end
         if (tx_timeout === 1'b1) begin
            checks++;
            if (q_tmo.size() == 0) begin
               errors++;
               $display("FAIL timeout_unexpected: cycle %0d, required none", cyc);
            end else begin
               t = q_tmo.pop_front();
               if (t != cyc) begin
                  errors++;
                  $display("FAIL timeout: cycle %0d, required cycle %0d", cyc, t);
               end
            end
         end
         if (idle_chk) begin
            checks++;
            outs = {gmii_tx_en, gmii_txd, tx_busy, grant_id, tx_timeout,
                    arp_tx_en, icmp_tx_en, udp_tx_en};
            if (outs !== 15'd0) begin
               errors++;
               $display("FAIL idle: cycle %0d outputs=%h, required 0", cyc, outs);
            end
         end
         if (final_chk) begin
            checks++;
            if (q_start.size() != 0) begin
               errors++;
               $display("FAIL start_missing: got %0d left, required 0", q_start.size());
            end
            checks++;
            if (q_byte.size() != 0) begin
               errors++;
               $display("FAIL byte_missing: got %0d left, required 0", q_byte.size());
            end
            checks++;
            if (q_tmo.size() != 0) begin
               errors++;
               $display("FAIL timeout_missing: got %0d left, required 0", q_tmo.size());
            end
         end
      end
   end

   // Client model: each generator answers its start with done after dly.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            done_v[k] = 1'b0;
            if (dly[k] != 0 && start_cnt[k] != served[k] &&
                cyc == start_cyc[k] + dly[k]) begin
               done_v[k] = 1'b1;
               served[k] = start_cnt[k];
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: cycle %0d, required completion", cyc);
      $fatal(1, "bench time limit");
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_idle();
      idle_chk = 1'b1;
      @(posedge clk);
      #1;
      idle_chk = 1'b0;
   endtask

   task automatic exp_start(input int c, input int id);
      ev_t e;
      e.cyc = c;
      e.id  = id;
      q_start.push_back(e);
   endtask

   task automatic exp_byte(input int c, input logic [7:0] d);
      by_t b;
      b.cyc = c;
      b.d   = d;
      q_byte.push_back(b);
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      n = cyc + 2;
      goto(n);
      pulse_idle();
      rst = 1'b0;
   endtask

   initial begin
      int t;
      int s;
      rst = 1'b1;
      {arp_tx_req, icmp_tx_req, udp_tx_req} = 3'b000;
      {arp_gmii_tx_en, icmp_gmii_tx_en, udp_gmii_tx_en} = 3'b000;
      arp_gmii_txd  = 8'd0;
      icmp_gmii_txd = 8'd0;
      udp_gmii_txd  = 8'd0;
      @(posedge clk);
      #1;

      // ICMP only, with a short byte burst
      do_reset();
      t = cyc + 1;
      goto(t);
      exp_start(t + 2, 2);
      exp_byte(t + 6, 8'h55);
      exp_byte(t + 7, 8'h55);
      exp_byte(t + 8, 8'hD5);
      icmp_tx_req = 1'b1;
      goto(t + 1);
      icmp_tx_req = 1'b0;
      goto(t + 5);
      icmp_gmii_tx_en = 1'b1;
      icmp_gmii_txd   = 8'h55;
      goto(t + 7);
      icmp_gmii_txd = 8'hD5;
      goto(t + 8);
      icmp_gmii_tx_en = 1'b0;
      icmp_gmii_txd   = 8'd0;
      goto(t + 40);
      pulse_idle();

      // all three at once: ARP, ICMP, UDP, 13 cycles done-to-start
      do_reset();
      t = cyc + 1;
      goto(t);
      exp_start(t + 2, 1);
      exp_start(t + 35, 2);
      exp_start(t + 68, 3);
      {arp_tx_req, icmp_tx_req, udp_tx_req} = 3'b111;
      goto(t + 1);
      {arp_tx_req, icmp_tx_req, udp_tx_req} = 3'b000;
      goto(t + 105);
      pulse_idle();

      // round-robin, plus done from non-granted clients
      do_reset();
      t = cyc + 1;
      goto(t);
      exp_start(t + 2, 2);
      exp_start(t + 35, 3);
      exp_start(t + 68, 3);
      exp_start(t + 101, 2);
      {icmp_tx_req, udp_tx_req} = 2'b11;
      goto(t + 1);
      {icmp_tx_req, udp_tx_req} = 2'b00;
      goto(t + 10);
      spur = 3'b101;
      goto(t + 11);
      spur = 3'b000;
      goto(t + 60);
      {icmp_tx_req, udp_tx_req} = 2'b11;
      goto(t + 61);
      {icmp_tx_req, udp_tx_req} = 2'b00;
      goto(t + 140);
      pulse_idle();

      // watchdog abort of a stuck UDP client, ICMP served afterwards
      do_reset();
      dly[2] = 0;
      t = cyc + 1;
      s = t + 2;
      goto(t);
      exp_start(s, 3);
      for (int c = s + 1; c <= s + 99; c++)
         exp_byte(c + 1, 8'(c - s));
      q_tmo.push_back(s + 100);
      exp_start(t + 115, 2);
      udp_tx_req = 1'b1;
      goto(t + 1);
      udp_tx_req = 1'b0;
      for (int c = s + 1; c <= s + 104; c++) begin
         goto(c);
         udp_gmii_tx_en = 1'b1;
         udp_gmii_txd   = 8'(c - s);
         icmp_tx_req    = (c == t + 10);
      end
      goto(s + 105);
      udp_gmii_tx_en = 1'b0;
      udp_gmii_txd   = 8'd0;
      goto(t + 150);
      pulse_idle();
      dly[2] = 20;

      // request in own START cycle is queued
      do_reset();
      t = cyc + 1;
      goto(t);
      exp_start(t + 2, 2);
      exp_start(t + 35, 2);
      icmp_tx_req = 1'b1;
      goto(t + 1);
      icmp_tx_req = 1'b0;
      goto(t + 2);
      icmp_tx_req = 1'b1;
      goto(t + 3);
      icmp_tx_req = 1'b0;
      goto(t + 70);
      pulse_idle();

      // reset during ARP frame with UDP pending
      do_reset();
      t = cyc + 1;
      goto(t);
      exp_start(t + 2, 1);
      exp_byte(t + 5, 8'h11);
      exp_byte(t + 6, 8'h22);
      exp_byte(t + 7, 8'h33);
      {arp_tx_req, udp_tx_req} = 2'b11;
      goto(t + 1);
      {arp_tx_req, udp_tx_req} = 2'b00;
      goto(t + 4);
      arp_gmii_tx_en = 1'b1;
      arp_gmii_txd   = 8'h11;
      goto(t + 5);
      arp_gmii_txd = 8'h22;
      goto(t + 6);
      arp_gmii_txd = 8'h33;
      goto(t + 7);
      arp_gmii_tx_en = 1'b0;
      arp_gmii_txd   = 8'd0;
      goto(t + 10);
      arp_gmii_tx_en = 1'b1;
      arp_gmii_txd   = 8'h77;
      rst = 1'b1;
      goto(t + 11);
      rst = 1'b0;
      arp_gmii_tx_en = 1'b0;
      arp_gmii_txd   = 8'd0;
      pulse_idle();
      goto(t + 60);
      pulse_idle();

      final_chk = 1'b1;
      @(posedge clk);
      #1;
      final_chk = 1'b0;
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
